ef_sram_port_arbiter: RTL and testbench

Shares the single-port EF_SRAM macro behind the south-terminal EF_SRAM tile between two fabric-side requesters. Zero-fills the whole array after reset, then arbitrates valid/ready requests round-robin (or fixed-priority, see Configuration). Issues at most one SRAM access per cycle and returns read data to the owning port with fixed latency. Sits between the fabric user logic and the EF_SRAM macro pins.

---
 rtl/ef_sram_port_arbiter_if.sv | 55 +++++
 rtl/ef_sram_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_ef_sram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ef_sram_port_arbiter_if.sv
// rtl/ef_sram_port_arbiter_if.sv - request/response and SRAM macro bundle for ef_sram_port_arbiter
//
// Groups the two fabric requester ports, the init status flag and the
// EF_SRAM macro pins into one bundle.
//   slave  modport : the arbiter (takes requests, drives the macro)
//   master modport : the fabric requesters and the macro model (drive
//                    requests and sram_rdata, observe everything else)
interface ef_sram_port_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          resp0_valid;
    logic [DW-1:0] resp0_rdata;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          resp1_valid;
    logic [DW-1:0] resp1_rdata;

    logic          init_done;

    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  sram_rdata,
        output req0_ready, resp0_valid, resp0_rdata,
        output req1_ready, resp1_valid, resp1_rdata,
        output init_done,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output sram_rdata,
        input  req0_ready, resp0_valid, resp0_rdata,
        input  req1_ready, resp1_valid, resp1_rdata,
        input  init_done,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/ef_sram_port_arbiter.sv
// rtl/ef_sram_port_arbiter.sv - two-port arbiter in front of the single-port EF_SRAM macro
//
// After reset the whole array (2^AW words) is zero-filled, one word per
// cycle, then valid/ready requests from two fabric ports are arbitrated
// onto the macro, at most one access per cycle.  Read data returns to the
// owning port two cycles after the handshake.
//
// Ports:
//   UserCLK  - sole clock, rising edge
//   RST      - asynchronous active-high reset
//   bus      - ef_sram_port_arbiter_if.slave: req0/req1 request ports,
//              resp0/resp1 read responses, init_done, sram_* macro pins
//
// Build option: define EF_SRAM_ARB_FIXED_PRIO_EN for fixed priority
// (port 0 always wins contention); otherwise round-robin.
module ef_sram_port_arbiter #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic                  UserCLK,
    input  logic                  RST,
    ef_sram_port_arbiter_if.slave bus
);
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_cnt;
    logic          gnt0;
    logic          gnt1;
    logic          rdy0;
    logic          rdy1;
    logic          init_done_c;

    logic          sram_en_q;
    logic          sram_we_q;
    logic [AW-1:0] sram_addr_q;
    logic [DW-1:0] sram_wdata_q;
    // Owner tag of the read currently on the macro pins, then of the data
    // coming back one cycle later.
    logic          s_rd0;
    logic          s_rd1;
    logic          resp_v0;
    logic          resp_v1;

`ifdef EF_SRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid & ~bus.req0_valid;
    end
`else
    // rr_ptr names the port that wins the next contention; it flips away
    // from whichever port was just accepted.
    logic rr_ptr;

    always_comb begin
        gnt0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr);
        gnt1 = bus.req1_valid & (~bus.req0_valid |  rr_ptr);
    end

    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            rr_ptr <= 1'b0;
        end else if (rdy0) begin
            rr_ptr <= 1'b1;
        end else if (rdy1) begin
            rr_ptr <= 1'b0;
        end
    end
`endif

    // State register.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave CLEAR once the last address has been issued.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == {AW{1'b1}}) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // Output logic.
    always_comb begin
        rdy0        = 1'b0;
        rdy1        = 1'b0;
        init_done_c = 1'b0;
        if (state == RUN) begin
            rdy0        = gnt0;
            rdy1        = gnt1;
            init_done_c = 1'b1;
        end
    end

    // Macro command register, clear counter and read-owner pipeline.
    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            clr_cnt      <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            s_rd0        <= 1'b0;
            s_rd1        <= 1'b0;
            resp_v0      <= 1'b0;
            resp_v1      <= 1'b0;
        end else begin
            s_rd0   <= rdy0 & ~bus.req0_we;
            s_rd1   <= rdy1 & ~bus.req1_we;
            resp_v0 <= s_rd0;
            resp_v1 <= s_rd1;
            if (state == CLEAR) begin
                sram_en_q    <= 1'b1;
                sram_we_q    <= 1'b1;
                sram_addr_q  <= clr_cnt;
                sram_wdata_q <= '0;
                clr_cnt      <= clr_cnt + 1'b1;
            end else if (rdy0) begin
                sram_en_q    <= 1'b1;
                sram_we_q    <= bus.req0_we;
                sram_addr_q  <= bus.req0_addr;
                sram_wdata_q <= bus.req0_wdata;
            end else if (rdy1) begin
                sram_en_q    <= 1'b1;
                sram_we_q    <= bus.req1_we;
                sram_addr_q  <= bus.req1_addr;
                sram_wdata_q <= bus.req1_wdata;
            end else begin
                sram_en_q <= 1'b0;
                sram_we_q <= 1'b0;
            end
        end
    end

    assign bus.req0_ready  = rdy0;
    assign bus.req1_ready  = rdy1;
    assign bus.init_done   = init_done_c;
    assign bus.sram_en     = sram_en_q;
    assign bus.sram_we     = sram_we_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_wdata  = sram_wdata_q;
    assign bus.resp0_valid = resp_v0;
    assign bus.resp1_valid = resp_v1;
    assign bus.resp0_rdata = bus.sram_rdata;
    assign bus.resp1_rdata = bus.sram_rdata;
endmodule

// File: tb/tb_ef_sram_port_arbiter.sv
// tb/tb_ef_sram_port_arbiter.sv - self-checking bench for ef_sram_port_arbiter
module tb_ef_sram_port_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
`ifdef EF_SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        bit            v0;
        bit            we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        bit            v1;
        bit            we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        bit            er0;
        bit            er1;
    } row_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    logic UserCLK = 1'b0;
    logic RST     = 1'b1;
    always #5 UserCLK = ~UserCLK;

    ef_sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ef_sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .UserCLK (UserCLK),
        .RST     (RST),
        .bus     (bus)
    );

    // Macro model: filled with junk while RST is high so the zero-fill is visible.
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] sram_q;
    always @(posedge UserCLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 32'hA5A5_0000 | DW'(i);
        end else if (bus.sram_en) begin
            if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
            else             sram_q <= sram_mem[bus.sram_addr];
        end
    end
    assign bus.sram_rdata = sram_q;

    int cyc = 0;
    always @(posedge UserCLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: word array, preferred-port number, queue of due responses.
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_prio;
    resp_t         exp_q[$];

    row_t tbl [13];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_prio = 0;
        exp_q.delete();
    endtask

    // Called #1 after the inputs for the current cycle have been applied.
    task automatic cycle_check(input row_t r, input bit use_tbl);
        bit            m0, m1, e0, e1;
        logic [DW-1:0] ed;
        if (FIXED) begin
            m0 = r.v0;
        end else if (r.v0 && r.v1) begin
            m0 = (ref_prio == 0);
        end else begin
            m0 = r.v0;
        end
        m1 = r.v1 && !m0;
        if (use_tbl) begin
            check("tbl_ready0", {31'd0, bus.req0_ready}, {31'd0, r.er0});
            check("tbl_ready1", {31'd0, bus.req1_ready}, {31'd0, r.er1});
        end else begin
            check("ready0", {31'd0, bus.req0_ready}, {31'd0, m0});
            check("ready1", {31'd0, bus.req1_ready}, {31'd0, m1});
        end
        e0 = 1'b0;
        e1 = 1'b0;
        ed = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].port == 0) e0 = 1'b1;
            else                    e1 = 1'b1;
            ed = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        check("resp0_valid", {31'd0, bus.resp0_valid}, {31'd0, e0});
        check("resp1_valid", {31'd0, bus.resp1_valid}, {31'd0, e1});
        if (e0) check("resp0_rdata", bus.resp0_rdata, ed);
        if (e1) check("resp1_rdata", bus.resp1_rdata, ed);
        if (m0) begin
            if (r.we0) ref_mem[r.a0] = r.d0;
            else       exp_q.push_back('{port: 0, data: ref_mem[r.a0], due: cyc + 2});
            ref_prio = 1;
        end else if (m1) begin
            if (r.we1) ref_mem[r.a1] = r.d1;
            else       exp_q.push_back('{port: 1, data: ref_mem[r.a1], due: cyc + 2});
            ref_prio = 0;
        end
    endtask

    task automatic drive(input row_t r);
        bus.req0_valid = r.v0;
        bus.req0_we    = r.we0;
        bus.req0_addr  = r.a0;
        bus.req0_wdata = r.d0;
        bus.req1_valid = r.v1;
        bus.req1_we    = r.we1;
        bus.req1_addr  = r.a1;
        bus.req1_wdata = r.d1;
    endtask

    task automatic step(input row_t r, input bit use_tbl);
        @(negedge UserCLK);
        drive(r);
        #1;
        cycle_check(r, use_tbl);
    endtask

    // Must be entered at a negedge; releases RST and follows the zero-fill.
    task automatic clear_check();
        int   nwr;
        row_t idle;
        idle  = '{0, 0, '0, '0, 0, 0, '0, '0, 0, 0};
        nwr   = 0;
        RST   = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) @(negedge UserCLK);
            if (k == DEPTH) drive(idle);
            #1;
            check("clr_en", {31'd0, bus.sram_en}, {31'd0, (k >= 1 && k <= DEPTH)});
            if (bus.sram_en) begin
                check("clr_we", {31'd0, bus.sram_we}, 32'd1);
                check("clr_addr", {28'd0, bus.sram_addr}, nwr);
                check("clr_wdata", bus.sram_wdata, '0);
                nwr++;
            end
            if (k < DEPTH) check("clr_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            check("clr_init_done", {31'd0, bus.init_done}, {31'd0, (k >= DEPTH)});
            check("clr_resp", {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
        end
        check("clr_write_count", nwr, DEPTH);
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;

        // Contention on reads, then write/read-back, RAW and unwritten reads.
        tbl[0]  = '{1, 0, 4'd7, '0, 1, 0, 4'd5, '0, 1, 0};
        tbl[1]  = '{1, 0, 4'd7, '0, 1, 0, 4'd5, '0, FIXED, !FIXED};
        tbl[2]  = '{1, 0, 4'd7, '0, 1, 0, 4'd5, '0, 1, 0};
        tbl[3]  = '{1, 0, 4'd7, '0, 1, 0, 4'd5, '0, FIXED, !FIXED};
        tbl[4]  = '{1, 1, 4'd3, 32'hDEADBEEF, 0, 0, '0, '0, 1, 0};
        tbl[5]  = '{1, 0, 4'd3, '0, 0, 0, '0, '0, 1, 0};
        tbl[6]  = '{0, 0, '0, '0, 0, 0, '0, '0, 0, 0};
        tbl[7]  = '{0, 0, '0, '0, 1, 1, 4'd5, 32'h12345678, 0, 1};
        tbl[8]  = '{0, 0, '0, '0, 1, 0, 4'd5, '0, 0, 1};
        tbl[9]  = '{1, 1, 4'd9, 32'hCAFE0001, 1, 0, 4'd9, '0, 1, 0};
        tbl[10] = '{0, 0, '0, '0, 1, 0, 4'd9, '0, 0, 1};
        tbl[11] = '{0, 0, '0, '0, 0, 0, '0, '0, 0, 0};
        tbl[12] = '{0, 0, '0, '0, 0, 0, '0, '0, 0, 0};

        // Hold reset, requests asserted so ready must stay low in CLEAR.
        r = '{1, 0, 4'd1, '0, 1, 0, 4'd2, '0, 0, 0};
        drive(r);
        RST = 1'b1;
        repeat (3) @(posedge UserCLK);
        #1;
        check("rst_init_done", {31'd0, bus.init_done}, 32'd0);
        check("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        check("rst_sram_en", {31'd0, bus.sram_en}, 32'd0);
        @(negedge UserCLK);
        clear_check();

        for (int i = 0; i < 13; i++) step(tbl[i], 1'b1);

        // Randomized traffic checked against the reference.
        for (int i = 0; i < 400; i++) begin
            r.v0  = ($urandom_range(0, 3) != 0);
            r.we0 = $urandom_range(0, 1);
            r.a0  = AW'($urandom_range(0, DEPTH - 1));
            r.d0  = $urandom;
            r.v1  = ($urandom_range(0, 3) != 0);
            r.we1 = $urandom_range(0, 1);
            r.a1  = AW'($urandom_range(0, DEPTH - 1));
            r.d1  = $urandom;
            r.er0 = 0;
            r.er1 = 0;
            step(r, 1'b0);
        end
        r = '{0, 0, '0, '0, 0, 0, '0, '0, 0, 0};
        repeat (3) step(r, 1'b0);
        check("drain_empty", exp_q.size(), 0);

        // Reset one cycle after a read handshake: no response, CLEAR restarts.
        r = '{1, 0, 4'd3, '0, 0, 0, '0, '0, 0, 0};
        step(r, 1'b0);
        @(negedge UserCLK);
        RST = 1'b1;
        #1;
        check("arst_sram_en", {31'd0, bus.sram_en}, 32'd0);
        check("arst_sram_addr", {28'd0, bus.sram_addr}, 32'd0);
        check("arst_init_done", {31'd0, bus.init_done}, 32'd0);
        check("arst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        check("arst_resp", {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
        @(negedge UserCLK);
        #1;
        check("arst_resp_due", {30'd0, bus.resp1_valid, bus.resp0_valid}, 32'd0);
        clear_check();

        // Port 1 reads addr 3 (written before the second reset) -> zero again.
        r = '{0, 0, '0, '0, 1, 0, 4'd3, '0, 0, 0};
        step(r, 1'b0);
        r = '{0, 0, '0, '0, 0, 0, '0, '0, 0, 0};
        repeat (3) step(r, 1'b0);
        check("final_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
